// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: on a demand miss, fetches the following cache line once the demand fill ends
// and buffers it for install. Optional macro PF_PAGE_CROSS_BLOCK_EN suppresses prefetches that leave the 4 KiB page.
module next_line_prefetcher #(
  parameter int ADDR_W      = 32,
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prefetch_start,
  input  logic [ADDR_W-1:0]    mem_address,
  input  logic                 pf_accept,
  output logic                 prefetch_ready,
  output logic [ADDR_W-1:0]    pf_addr,
  output logic [LINE_BITS-1:0] pf_line,
  output logic                 pf_pmem_read,
  output logic [ADDR_W-1:0]    pf_pmem_address,
  input  logic [LINE_BITS-1:0] pf_pmem_rdata,
  input  logic                 pf_pmem_resp
);

  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(1) << OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, ARMED, FETCH, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic              fetch_ok;

  // Line-align and step one line; the adder wraps naturally at the top of the address space.
  function automatic logic [ADDR_W-1:0] next_line_addr(input logic [ADDR_W-1:0] a);
    return (a & ~(LINE_BYTES - ADDR_W'(1))) + LINE_BYTES;
  endfunction

`ifdef PF_PAGE_CROSS_BLOCK_EN
  localparam int PAGE_BITS = 12;

  logic cross_page;

  function automatic logic crosses_page(input logic [ADDR_W-1:0] miss,
                                        input logic [ADDR_W-1:0] nxt);
    return miss[ADDR_W-1:PAGE_BITS] != nxt[ADDR_W-1:PAGE_BITS];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cross_page <= 1'b0;
    end else if (state == IDLE && prefetch_start) begin
      cross_page <= crosses_page(mem_address, next_line_addr(mem_address));
    end
  end

  assign fetch_ok = !cross_page;
`else
  assign fetch_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      next_addr       <= '0;
      prefetch_ready  <= 1'b0;
      pf_pmem_read    <= 1'b0;
      pf_pmem_address <= '0;
      pf_addr         <= '0;
      pf_line         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (prefetch_start) begin
            next_addr <= next_line_addr(mem_address);
            state     <= ARMED;
          end
        end
        // Demand fill is over once the cache leaves its miss state.
        ARMED: begin
          if (!prefetch_start) begin
            if (fetch_ok) begin
              pf_pmem_read    <= 1'b1;
              pf_pmem_address <= next_addr;
              state           <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FETCH: begin
          if (pf_pmem_resp) begin
            pf_pmem_read   <= 1'b0;
            pf_line        <= pf_pmem_rdata;
            pf_addr        <= next_addr;
            prefetch_ready <= 1'b1;
            state          <= READY;
          end
        end
        READY: begin
          if (pf_accept) begin
            prefetch_ready <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
